// File: rtl/ctrl_resolve_stage.sv
// Control-lane resolve stage: registers control ALU results for writeback/active-list update,
// keeps the oldest branch/JALR mispredict as a held fetch redirect, and buffers one CSR write.
// Latency 1 cycle (writeback, redirect, CSR write); redirect held until redirectReady_i, CSR until csrCommit_i.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush_i, alHead_i          squash (highest priority), active-list head used as the age base
//   valid_i .. isControl_i     control ALU packet (id, result, resolved target, flags)
//   csrWrEn_i/Data_i/Addr_i    CSR write request from the ALU; csrCommit_i releases it
//   wb*_o, ctrlDone_o/Misp_o   registered writeback and active-list update
//   redirect*_o, redirectReady_i  fetch redirect valid/ready handshake
//   csrWr*_o, csrPending_o, csrOverflow_o  CSR file write port, buffer status, sticky protocol error
module ctrl_resolve_stage #(
  parameter int SIZE_PC       = 32,
  parameter int SIZE_DATA     = 32,
  parameter int SIZE_AL_LOG   = 7,
  parameter int CSR_WIDTH     = 32,
  parameter int CSR_WIDTH_LOG = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [SIZE_AL_LOG-1:0]   alHead_i,
  input  logic                     valid_i,
  input  logic [SIZE_AL_LOG-1:0]   alID_i,
  input  logic [SIZE_PC-1:0]       result_i,
  input  logic [SIZE_PC-1:0]       nextPC_i,
  input  logic                     mispredict_i,
  input  logic                     executed_i,
  input  logic                     destValid_i,
  input  logic                     isControl_i,
  input  logic                     csrWrEn_i,
  input  logic [CSR_WIDTH-1:0]     csrWrData_i,
  input  logic [CSR_WIDTH_LOG-1:0] csrWrAddr_i,
  input  logic                     csrCommit_i,
  output logic                     wbValid_o,
  output logic [SIZE_PC-1:0]       wbData_o,
  output logic [SIZE_AL_LOG-1:0]   wbALID_o,
  output logic                     ctrlDone_o,
  output logic                     ctrlMisp_o,
  output logic                     redirectValid_o,
  input  logic                     redirectReady_i,
  output logic [SIZE_PC-1:0]       redirectPC_o,
  output logic [SIZE_AL_LOG-1:0]   redirectALID_o,
  output logic                     csrWrEn_o,
  output logic [CSR_WIDTH-1:0]     csrWrData_o,
  output logic [CSR_WIDTH_LOG-1:0] csrWrAddr_o,
  output logic                     csrPending_o,
  output logic                     csrOverflow_o
);

  typedef enum logic [1:0] {IDLE, PENDING, DRAIN} state_e;

  // The control flag is not needed here: every packet reaching this stage is a control op.
  logic unused_is_control;
  assign unused_is_control = isControl_i;

  // ---------------- writeback register ----------------
  logic                   wb_valid_q, wb_valid_d;
  logic [SIZE_DATA-1:0]   wb_data_q, wb_data_d;
  logic [SIZE_AL_LOG-1:0] wb_alid_q, wb_alid_d;
  logic                   done_q, done_d;
  logic                   misp_q, misp_d;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = '0;
    wb_alid_d  = '0;
    done_d     = 1'b0;
    misp_d     = 1'b0;
    if (!flush_i) begin
      done_d     = valid_i & executed_i;
      wb_valid_d = valid_i & executed_i & destValid_i;
      misp_d     = mispredict_i;
      wb_data_d  = result_i;
      wb_alid_d  = alID_i;
    end
  end

  // ---------------- redirect arbitration ----------------
  state_e                 state_q, state_d;
  logic [SIZE_PC-1:0]     held_pc_q, held_pc_d;
  logic [SIZE_AL_LOG-1:0] held_id_q, held_id_d;

  logic                   new_misp;
  logic [SIZE_AL_LOG-1:0] age_new, age_held;
  logic                   new_older;

  assign new_misp  = valid_i & executed_i & mispredict_i & ~flush_i;
  // Ages wrap modulo the active-list size, so plain subtraction truncated to the index width.
  assign age_new   = alID_i - alHead_i;
  assign age_held  = held_id_q - alHead_i;
  assign new_older = age_new < age_held;

  always_comb begin
    state_d   = state_q;
    held_pc_d = held_pc_q;
    held_id_d = held_id_q;
    if (flush_i) begin
      state_d   = IDLE;
      held_pc_d = '0;
      held_id_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_misp) begin
            state_d   = PENDING;
            held_pc_d = nextPC_i;
            held_id_d = alID_i;
          end
        end
        PENDING: begin
          // Whether or not fetch accepted the held entry this cycle, an older
          // mispredict supersedes it and must itself be redirected.
          if (new_misp && new_older) begin
            held_pc_d = nextPC_i;
            held_id_d = alID_i;
          end else if (redirectReady_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          // held_id_q still names the last accepted redirect; only older ones matter.
          if (new_misp && new_older) begin
            state_d   = PENDING;
            held_pc_d = nextPC_i;
            held_id_d = alID_i;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- CSR write buffer ----------------
  logic                     csr_pend_q, csr_pend_d;
  logic [CSR_WIDTH-1:0]     buf_data_q, buf_data_d;
  logic [CSR_WIDTH_LOG-1:0] buf_addr_q, buf_addr_d;
  logic                     csr_wen_q, csr_wen_d;
  logic [CSR_WIDTH-1:0]     csr_wdata_q, csr_wdata_d;
  logic [CSR_WIDTH_LOG-1:0] csr_waddr_q, csr_waddr_d;
  logic                     csr_ovf_q, csr_ovf_d;
  logic                     csr_cap, csr_commit;

  assign csr_cap    = valid_i & csrWrEn_i & ~flush_i;
  assign csr_commit = csrCommit_i & csr_pend_q;

  always_comb begin
    csr_pend_d  = csr_pend_q;
    buf_data_d  = buf_data_q;
    buf_addr_d  = buf_addr_q;
    csr_wen_d   = 1'b0;
    csr_wdata_d = csr_wdata_q;
    csr_waddr_d = csr_waddr_q;
    csr_ovf_d   = csr_ovf_q;
    if (flush_i) begin
      csr_pend_d  = 1'b0;
      buf_data_d  = '0;
      buf_addr_d  = '0;
      csr_wdata_d = '0;
      csr_waddr_d = '0;
    end else begin
      if (csr_commit) begin
        csr_wen_d   = 1'b1;
        csr_wdata_d = buf_data_q;
        csr_waddr_d = buf_addr_q;
        csr_pend_d  = 1'b0;
      end
      if (csr_cap) begin
        // A commit in the same cycle frees the slot, so only a capture into a
        // still-occupied buffer is a protocol error.
        if (csr_pend_q && !csr_commit) begin
          csr_ovf_d = 1'b1;
        end else begin
          buf_data_d = csrWrData_i;
          buf_addr_d = csrWrAddr_i;
          csr_pend_d = 1'b1;
        end
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_alid_q   <= '0;
      done_q      <= 1'b0;
      misp_q      <= 1'b0;
      state_q     <= IDLE;
      held_pc_q   <= '0;
      held_id_q   <= '0;
      csr_pend_q  <= 1'b0;
      buf_data_q  <= '0;
      buf_addr_q  <= '0;
      csr_wen_q   <= 1'b0;
      csr_wdata_q <= '0;
      csr_waddr_q <= '0;
      csr_ovf_q   <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_alid_q   <= wb_alid_d;
      done_q      <= done_d;
      misp_q      <= misp_d;
      state_q     <= state_d;
      held_pc_q   <= held_pc_d;
      held_id_q   <= held_id_d;
      csr_pend_q  <= csr_pend_d;
      buf_data_q  <= buf_data_d;
      buf_addr_q  <= buf_addr_d;
      csr_wen_q   <= csr_wen_d;
      csr_wdata_q <= csr_wdata_d;
      csr_waddr_q <= csr_waddr_d;
      csr_ovf_q   <= csr_ovf_d;
    end
  end

  assign wbValid_o       = wb_valid_q;
  assign wbData_o        = wb_data_q;
  assign wbALID_o        = wb_alid_q;
  assign ctrlDone_o      = done_q;
  assign ctrlMisp_o      = misp_q;
  assign redirectValid_o = (state_q == PENDING);
  assign redirectPC_o    = held_pc_q;
  assign redirectALID_o  = held_id_q;
  assign csrWrEn_o       = csr_wen_q;
  assign csrWrData_o     = csr_wdata_q;
  assign csrWrAddr_o     = csr_waddr_q;
  assign csrPending_o    = csr_pend_q;
  assign csrOverflow_o   = csr_ovf_q;

endmodule

// File: tb/tb_ctrl_resolve_stage.sv
// Self-checking bench for ctrl_resolve_stage: directed scenarios plus random traffic
// against a behavioural model (age arithmetic on ints, CSR buffer as a queue).
module tb_ctrl_resolve_stage;
  localparam int PCW = 32;
  localparam int ALW = 7;
  localparam int CW  = 32;
  localparam int CAW = 12;

  logic           clk = 1'b0;
  logic           reset, flush_i;
  logic [ALW-1:0] alHead_i, alID_i;
  logic           valid_i;
  logic [PCW-1:0] result_i, nextPC_i;
  logic           mispredict_i, executed_i, destValid_i, isControl_i;
  logic           csrWrEn_i, csrCommit_i, redirectReady_i;
  logic [CW-1:0]  csrWrData_i;
  logic [CAW-1:0] csrWrAddr_i;

  logic           wbValid_o, ctrlDone_o, ctrlMisp_o, redirectValid_o;
  logic [PCW-1:0] wbData_o, redirectPC_o;
  logic [ALW-1:0] wbALID_o, redirectALID_o;
  logic           csrWrEn_o, csrPending_o, csrOverflow_o;
  logic [CW-1:0]  csrWrData_o;
  logic [CAW-1:0] csrWrAddr_o;

  always #5 clk = ~clk;

  ctrl_resolve_stage dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .alHead_i(alHead_i),
    .valid_i(valid_i), .alID_i(alID_i), .result_i(result_i), .nextPC_i(nextPC_i),
    .mispredict_i(mispredict_i), .executed_i(executed_i), .destValid_i(destValid_i),
    .isControl_i(isControl_i), .csrWrEn_i(csrWrEn_i), .csrWrData_i(csrWrData_i),
    .csrWrAddr_i(csrWrAddr_i), .csrCommit_i(csrCommit_i),
    .wbValid_o(wbValid_o), .wbData_o(wbData_o), .wbALID_o(wbALID_o),
    .ctrlDone_o(ctrlDone_o), .ctrlMisp_o(ctrlMisp_o),
    .redirectValid_o(redirectValid_o), .redirectReady_i(redirectReady_i),
    .redirectPC_o(redirectPC_o), .redirectALID_o(redirectALID_o),
    .csrWrEn_o(csrWrEn_o), .csrWrData_o(csrWrData_o), .csrWrAddr_o(csrWrAddr_o),
    .csrPending_o(csrPending_o), .csrOverflow_o(csrOverflow_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CW-1:0]  d;
    logic [CAW-1:0] a;
  } csr_t;

  csr_t           csr_buf[$];   // at most one entry
  int             m_st;         // 0 = idle, 1 = redirect pending, 2 = draining
  logic [PCW-1:0] m_pc;
  logic [ALW-1:0] m_id;
  logic           m_done, m_wbv, m_misp, m_wen, m_ovf;
  logic [PCW-1:0] m_data;
  logic [ALW-1:0] m_wbid;
  logic [CW-1:0]  m_wdata;
  logic [CAW-1:0] m_waddr;

  function automatic int age(input logic [ALW-1:0] x);
    return (int'(x) - int'(alHead_i) + 128) % 128;
  endfunction

  task automatic model_clear();
    m_st = 0; m_pc = '0; m_id = '0;
    m_done = 0; m_wbv = 0; m_misp = 0; m_data = '0; m_wbid = '0;
    m_wen = 0; m_wdata = '0; m_waddr = '0;
    csr_buf.delete();
  endtask

  task automatic model_step();
    bit   m, older, commit;
    csr_t e;
    if (reset) begin
      model_clear();
      m_ovf = 0;
      return;
    end
    if (flush_i) begin
      model_clear();
      return;
    end
    m_done = valid_i & executed_i;
    m_wbv  = valid_i & executed_i & destValid_i;
    m_misp = mispredict_i;
    m_data = result_i;
    m_wbid = alID_i;

    m     = valid_i & executed_i & mispredict_i;
    older = age(alID_i) < age(m_id);
    case (m_st)
      0: if (m) begin m_st = 1; m_pc = nextPC_i; m_id = alID_i; end
      1: begin
        if (redirectReady_i) begin
          if (m && older) begin m_pc = nextPC_i; m_id = alID_i; end
          else m_st = 2;
        end else if (m && older) begin
          m_pc = nextPC_i; m_id = alID_i;
        end
      end
      default: if (m && older) begin m_st = 1; m_pc = nextPC_i; m_id = alID_i; end
    endcase

    m_wen  = 0;
    commit = csrCommit_i && csr_buf.size() > 0;
    if (commit) begin
      e = csr_buf.pop_front();
      m_wen = 1; m_wdata = e.d; m_waddr = e.a;
    end
    if (valid_i && csrWrEn_i) begin
      if (csr_buf.size() > 0) m_ovf = 1;
      else csr_buf.push_back('{d: csrWrData_i, a: csrWrAddr_i});
    end
  endtask

  task automatic compare_all();
    chk("wbValid", wbValid_o, m_wbv);
    chk("wbData", wbData_o, m_data);
    chk("wbALID", wbALID_o, m_wbid);
    chk("ctrlDone", ctrlDone_o, m_done);
    chk("ctrlMisp", ctrlMisp_o, m_misp);
    chk("redirValid", redirectValid_o, m_st == 1);
    chk("redirPC", redirectPC_o, m_pc);
    chk("redirALID", redirectALID_o, m_id);
    chk("csrWrEn", csrWrEn_o, m_wen);
    chk("csrWrData", csrWrData_o, m_wdata);
    chk("csrWrAddr", csrWrAddr_o, m_waddr);
    chk("csrPending", csrPending_o, csr_buf.size() > 0);
    chk("csrOverflow", csrOverflow_o, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    reset = 0; flush_i = 0; valid_i = 0; alID_i = '0; result_i = '0; nextPC_i = '0;
    mispredict_i = 0; executed_i = 0; destValid_i = 0; isControl_i = 0;
    csrWrEn_i = 0; csrWrData_i = '0; csrWrAddr_i = '0; csrCommit_i = 0; redirectReady_i = 0;
  endtask

  task automatic pkt(input logic [ALW-1:0] id, input logic [PCW-1:0] pc, input logic misp);
    idle();
    valid_i = 1; executed_i = 1; destValid_i = 1; isControl_i = 1;
    alID_i = id; nextPC_i = pc; result_i = pc + 32'h4; mispredict_i = misp;
  endtask

  initial begin
    m_ovf = 0;
    model_clear();
    idle();
    alHead_i = '0;

    // 1: reset while a redirect is pending
    reset = 1; step();
    pkt(7'd9, 32'h900, 1); step();
    chk("t1_pending", redirectValid_o, 1);
    idle(); reset = 1; step();
    chk("t1_rv_clr", redirectValid_o, 0);
    chk("t1_pc_clr", redirectPC_o, 0);

    // 2: single mispredict with held handshake
    alHead_i = 7'd0;
    pkt(7'd5, 32'h2000, 1); step();
    chk("t2_misp", ctrlMisp_o, 1);
    chk("t2_alid", wbALID_o, 5);
    chk("t2_rv", redirectValid_o, 1);
    chk("t2_pc", redirectPC_o, 32'h2000);
    idle();
    repeat (3) begin
      step();
      chk("t2_hold_pc", redirectPC_o, 32'h2000);
      chk("t2_hold_rv", redirectValid_o, 1);
    end
    redirectReady_i = 1; step();
    chk("t2_accept", redirectValid_o, 0);
    idle(); flush_i = 1; step();

    // 3: oldest wins across index wrap
    alHead_i = 7'd120;
    pkt(7'd3, 32'h300, 1); step();
    pkt(7'd125, 32'h1250, 1); step();
    chk("t3_older", redirectALID_o, 125);
    pkt(7'd10, 32'h100, 1); step();
    chk("t3_younger", redirectALID_o, 125);
    chk("t3_pc", redirectPC_o, 32'h1250);
    idle(); flush_i = 1; step();

    // 4: drain filter
    alHead_i = 7'd0;
    pkt(7'd20, 32'h2020, 1); step();
    idle(); redirectReady_i = 1; step();
    chk("t4_drain", redirectValid_o, 0);
    pkt(7'd30, 32'h3030, 1); step();
    chk("t4_drop", redirectValid_o, 0);
    pkt(7'd15, 32'h1515, 1); step();
    chk("t4_older_rv", redirectValid_o, 1);
    chk("t4_older_pc", redirectPC_o, 32'h1515);
    idle(); flush_i = 1; step();
    chk("t4_flush", redirectValid_o, 0);

    // 5: CSR buffer
    idle(); valid_i = 1; csrWrEn_i = 1; csrWrAddr_i = 12'h001; csrWrData_i = 32'hA5; step();
    chk("t5_pend", csrPending_o, 1);
    chk("t5_nowen", csrWrEn_o, 0);
    idle(); csrCommit_i = 1; step();
    chk("t5_wen", csrWrEn_o, 1);
    chk("t5_addr", csrWrAddr_o, 12'h001);
    chk("t5_data", csrWrData_o, 32'hA5);
    idle(); step();
    chk("t5_pulse", csrWrEn_o, 0);
    chk("t5_empty", csrPending_o, 0);
    valid_i = 1; csrWrEn_i = 1; csrWrAddr_i = 12'h001; csrWrData_i = 32'hA5; step();
    csrWrData_i = 32'h5A; step();
    chk("t5_ovf", csrOverflow_o, 1);
    idle(); csrCommit_i = 1; step();
    chk("t5_keep", csrWrData_o, 32'hA5);
    idle(); flush_i = 1; step();
    chk("t5_ovf_sticky", csrOverflow_o, 1);
    idle(); reset = 1; step();
    chk("t5_ovf_rst", csrOverflow_o, 0);

    // 6: JAL writeback without mispredict
    pkt(7'd4, 32'h100, 0); result_i = 32'h104; step();
    chk("t6_wbv", wbValid_o, 1);
    chk("t6_data", wbData_o, 32'h104);
    chk("t6_rv", redirectValid_o, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      flush_i      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) alHead_i = ALW'($urandom);
      valid_i      = ($urandom_range(0, 3) != 0);
      executed_i   = ($urandom_range(0, 4) != 0);
      mispredict_i = ($urandom_range(0, 2) == 0);
      destValid_i  = 1'($urandom);
      isControl_i  = 1'($urandom);
      alID_i       = alHead_i + ALW'($urandom_range(0, 15));
      nextPC_i     = $urandom;
      result_i     = $urandom;
      csrWrEn_i    = ($urandom_range(0, 5) == 0);
      csrWrData_i  = $urandom;
      csrWrAddr_i  = CAW'($urandom);
      csrCommit_i  = ($urandom_range(0, 3) == 0);
      redirectReady_i = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
